// File: rtl/aud_i2s_recorder.sv
// WM8731 ADC I2S capture stage: deserialises one mono channel and offers each sample with its
// SRAM word address on a valid/ready port, under start/pause/stop record control.
module aud_i2s_recorder #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}},
  parameter int unsigned       CHANNEL  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_AUD_BCLK,
  input  logic              i_AUD_ADCLRCK,
  input  logic              i_AUD_ADCDAT,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_full
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic             CH_LVL   = (CHANNEL != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_PAUSE
  } state_e;

  logic [1:0]        bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic              bclk_prev_q, lrck_prev_q;
  logic              bclk_s, lrck_s, dat_s, bclk_rise, lrck_edge;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              word_done;

  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              full_q, full_d;
  logic              start_cmd, xfer, full_hit;

  assign bclk_s    = bclk_sync_q[1];
  assign lrck_s    = lrck_sync_q[1];
  assign dat_s     = dat_sync_q[1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  // Frame starts when the sampled frame clock has just entered the selected channel's level.
  assign lrck_edge = bclk_rise & (lrck_s == CH_LVL) & (lrck_prev_q != CH_LVL);

  assign start_cmd = i_start & ~i_pause & ~i_stop;
  assign xfer      = valid_q & i_ready;
  assign full_hit  = xfer & (addr_q == MAX_ADDR);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_cmd) state_d = S_WAIT;
      S_WAIT: begin
        if (i_stop)          state_d = S_IDLE;
        else if (i_pause)    state_d = S_PAUSE;
        else if (lrck_edge) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (i_stop)          state_d = S_IDLE;
        else if (i_pause)    state_d = S_PAUSE;
        else if (bclk_rise) begin
          shift_d   = {shift_q[DATA_W-2:0], dat_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            state_d   = S_WAIT;
          end
        end
      end
      S_PAUSE: begin
        if (i_stop)          state_d = S_IDLE;
        else if (start_cmd)  state_d = S_WAIT;
      end
      default:               state_d = S_IDLE;
    endcase
    if (full_hit) state_d = S_IDLE;
  end

  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    full_d  = full_q;
    if (xfer) begin
      valid_d = 1'b0;
      if (addr_q != MAX_ADDR) addr_d = addr_q + ADDR_W'(1);
    end
    if (full_hit) full_d = 1'b1;
    // A word finishing alongside the final transfer is discarded silently.
    if (word_done && !full_hit) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (state_q == S_IDLE && start_cmd) begin
      addr_d = '0;
      ovf_d  = 1'b0;
      full_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], i_AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], i_AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[0], i_AUD_ADCDAT};
      bclk_prev_q <= bclk_s;
      if (bclk_rise) lrck_prev_q <= lrck_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      full_q      <= full_d;
    end
  end

  assign o_data     = data_q;
  assign o_addr     = addr_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;
  assign o_full     = full_q;
  assign o_busy     = (state_q == S_WAIT) || (state_q == S_SHIFT);

endmodule

// File: tb/tb_aud_i2s_recorder.sv
// Directed bench for aud_i2s_recorder: three instances (default, MAX_ADDR=3, CHANNEL=1) share one
// emulated I2S codec; each scenario task drives stimulus and compares against hand-computed values.
module tb_aud_i2s_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic bclk, lrck, dat;
  logic start_a, pause_a, stop_a, ready_a;
  logic start_b, pause_b, stop_b, ready_b;
  logic start_c, pause_c, stop_c, ready_c;
  logic [15:0] data_a, data_b, data_c;
  logic [19:0] addr_a, addr_b, addr_c;
  logic valid_a, valid_b, valid_c, busy_a, busy_b, busy_c;
  logic ovf_a, ovf_b, ovf_c, full_a, full_b, full_c;

  int n_vec = 0;
  int n_err = 0;
  int hp = 3;
  logic [35:0] qa[$], qb[$], qc[$];

  aud_i2s_recorder #(.DATA_W(16), .ADDR_W(20), .MAX_ADDR(20'hFFFFF), .CHANNEL(0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_pause(pause_a), .i_stop(stop_a),
    .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
    .o_data(data_a), .o_addr(addr_a), .o_valid(valid_a), .i_ready(ready_a),
    .o_busy(busy_a), .o_overflow(ovf_a), .o_full(full_a));

  aud_i2s_recorder #(.DATA_W(16), .ADDR_W(20), .MAX_ADDR(20'd3), .CHANNEL(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_pause(pause_b), .i_stop(stop_b),
    .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
    .o_data(data_b), .o_addr(addr_b), .o_valid(valid_b), .i_ready(ready_b),
    .o_busy(busy_b), .o_overflow(ovf_b), .o_full(full_b));

  aud_i2s_recorder #(.DATA_W(16), .ADDR_W(20), .MAX_ADDR(20'hFFFFF), .CHANNEL(1)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_c), .i_pause(pause_c), .i_stop(stop_c),
    .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
    .o_data(data_c), .o_addr(addr_c), .o_valid(valid_c), .i_ready(ready_c),
    .o_busy(busy_c), .o_overflow(ovf_c), .o_full(full_c));

  // Transfer monitors: inputs change on the falling edge, so 2 ns later they hold until the next rise.
  always @(negedge clk) begin
    #2;
    if (valid_a && ready_a) qa.push_back({data_a, addr_a});
    if (valid_b && ready_b) qb.push_back({data_b, addr_b});
    if (valid_c && ready_c) qc.push_back({data_c, addr_c});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Codec behaviour: LRCK and DATA change on the BCLK falling edge.
  task automatic bclk_cycle(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; dat = d;
    tick(hp);
    bclk = 1'b1;
    tick(hp);
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w);
    bclk_cycle(lr, 1'b0);
    for (int i = 15; i >= 0; i--) bclk_cycle(lr, w[i]);
    bclk_cycle(lr, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l);
    send_slot(1'b1, r);
  endtask

  task automatic cmd(input int inst, input logic s, input logic p, input logic t);
    case (inst)
      0: begin start_a = s; pause_a = p; stop_a = t; end
      1: begin start_b = s; pause_b = p; stop_b = t; end
      default: begin start_c = s; pause_c = p; stop_c = t; end
    endcase
    tick(1);
    start_a = 0; pause_a = 0; stop_a = 0;
    start_b = 0; pause_b = 0; stop_b = 0;
    start_c = 0; pause_c = 0; stop_c = 0;
  endtask

  task automatic test_reset();
    n_vec++; if ({data_a, addr_a} !== 36'd0) begin n_err++;
      $display("FAIL reset_data_addr: got %h expected 0", {data_a, addr_a}); end
    n_vec++; if ({valid_a, busy_a, ovf_a, full_a} !== 4'b0000) begin n_err++;
      $display("FAIL reset_flags: got %b expected 0000", {valid_a, busy_a, ovf_a, full_a}); end
  endtask

  task automatic test_capture();
    qa.delete();
    ready_a = 1'b1;
    cmd(0, 1, 0, 0);
    n_vec++; if (busy_a !== 1'b1) begin n_err++;
      $display("FAIL busy_after_start: got %b expected 1", busy_a); end
    send_frame(16'hA5C3, 16'h1234);
    send_frame(16'hA5C3, 16'h1234);
    tick(4);
    n_vec++; if (qa.size() !== 2) begin n_err++;
      $display("FAIL capture_count: got %0d expected 2", qa.size()); end
    n_vec++; if (qa.size() > 0 && qa[0] !== {16'hA5C3, 20'd0}) begin n_err++;
      $display("FAIL capture_first: got %h expected a5c300000", qa[0]); end
    n_vec++; if (qa.size() > 1 && qa[1] !== {16'hA5C3, 20'd1}) begin n_err++;
      $display("FAIL capture_second: got %h expected a5c300001", qa[1]); end
    n_vec++; if ({addr_a, valid_a} !== {20'd2, 1'b0}) begin n_err++;
      $display("FAIL capture_end_addr: got %h/%b expected 2/0", addr_a, valid_a); end
  endtask

  task automatic test_backpressure();
    cmd(0, 0, 0, 1);
    ready_a = 1'b0;
    cmd(0, 1, 0, 0);
    qa.delete();
    send_frame(16'hA5C3, 16'h1234);
    send_frame(16'h5A5A, 16'h1234);
    tick(4);
    n_vec++; if (qa.size() !== 0) begin n_err++;
      $display("FAIL bp_no_transfer: got %0d expected 0", qa.size()); end
    n_vec++; if ({data_a, addr_a, valid_a} !== {16'hA5C3, 20'd0, 1'b1}) begin n_err++;
      $display("FAIL bp_hold: got %h/%h/%b expected a5c3/0/1", data_a, addr_a, valid_a); end
    n_vec++; if (ovf_a !== 1'b1) begin n_err++;
      $display("FAIL bp_overflow: got %b expected 1", ovf_a); end
    ready_a = 1'b1;
    tick(3);
    n_vec++; if (qa.size() !== 1 || qa[0] !== {16'hA5C3, 20'd0}) begin n_err++;
      $display("FAIL bp_drain: got %0d entries expected one a5c300000", qa.size()); end
    n_vec++; if ({addr_a, valid_a, ovf_a} !== {20'd1, 1'b0, 1'b1}) begin n_err++;
      $display("FAIL bp_after: got %h/%b/%b expected 1/0/1", addr_a, valid_a, ovf_a); end
  endtask

  task automatic test_pause();
    qa.delete();
    bclk_cycle(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bclk_cycle(1'b0, 1'b1);
    cmd(0, 0, 1, 0);
    n_vec++; if (busy_a !== 1'b0) begin n_err++;
      $display("FAIL pause_busy: got %b expected 0", busy_a); end
    for (int i = 0; i < 8; i++) bclk_cycle(1'b0, 1'b1);
    bclk_cycle(1'b0, 1'b0);
    send_slot(1'b1, 16'h1234);
    bclk_cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bclk_cycle(1'b0, 1'b1);
    cmd(0, 1, 0, 0);
    n_vec++; if (busy_a !== 1'b1) begin n_err++;
      $display("FAIL resume_busy: got %b expected 1", busy_a); end
    for (int i = 0; i < 12; i++) bclk_cycle(1'b0, 1'b1);
    bclk_cycle(1'b0, 1'b0);
    send_slot(1'b1, 16'h1234);
    send_frame(16'h3C96, 16'h1234);
    tick(4);
    n_vec++; if (qa.size() !== 1 || qa[0] !== {16'h3C96, 20'd1}) begin n_err++;
      $display("FAIL pause_capture: got %0d entries expected one 3c9600001", qa.size()); end
    n_vec++; if (addr_a !== 20'd2) begin n_err++;
      $display("FAIL pause_addr: got %h expected 2", addr_a); end
  endtask

  task automatic test_stop_reset();
    cmd(0, 0, 1, 1);
    n_vec++; if (busy_a !== 1'b0) begin n_err++;
      $display("FAIL stop_pause_busy: got %b expected 0", busy_a); end
    cmd(0, 1, 0, 0);
    n_vec++; if ({addr_a, ovf_a, busy_a} !== {20'd0, 1'b0, 1'b1}) begin n_err++;
      $display("FAIL stop_went_idle: got %h/%b/%b expected 0/0/1", addr_a, ovf_a, busy_a); end
    ready_a = 1'b1;
    send_frame(16'h1111, 16'h2222);
    ready_a = 1'b0;
    send_frame(16'h3333, 16'h4444);
    bclk_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bclk_cycle(1'b0, 1'b1);
    n_vec++; if ({data_a, addr_a, valid_a, busy_a} !== {16'h3333, 20'd1, 1'b1, 1'b1}) begin n_err++;
      $display("FAIL pre_reset: got %h/%h/%b/%b expected 3333/1/1/1", data_a, addr_a, valid_a, busy_a); end
    rst_n = 1'b0;
    tick(1);
    n_vec++; if ({data_a, addr_a, valid_a, busy_a, ovf_a, full_a} !== 40'd0) begin n_err++;
      $display("FAIL mid_reset: got %h/%h/%b/%b/%b/%b expected all 0",
               data_a, addr_a, valid_a, busy_a, ovf_a, full_a); end
    rst_n = 1'b1;
    send_slot(1'b1, 16'h0000);
  endtask

  task automatic test_full();
    qb.delete();
    ready_b = 1'b1;
    cmd(1, 1, 0, 0);
    send_frame(16'h1111, 16'hEEEE);
    send_frame(16'h2222, 16'hEEEE);
    send_frame(16'h3333, 16'hEEEE);
    send_frame(16'h4444, 16'hEEEE);
    send_frame(16'h5555, 16'hEEEE);
    tick(4);
    n_vec++; if (qb.size() !== 4) begin n_err++;
      $display("FAIL full_count: got %0d expected 4", qb.size()); end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      n_vec++;
      if (qb[i] !== {{4{4'(i + 1)}}, 20'(i)}) begin n_err++;
        $display("FAIL full_entry%0d: got %h expected %h", i, qb[i], {{4{4'(i + 1)}}, 20'(i)}); end
    end
    n_vec++; if ({full_b, busy_b, valid_b, addr_b} !== {1'b1, 1'b0, 1'b0, 20'd3}) begin n_err++;
      $display("FAIL full_state: got %b/%b/%b/%h expected 1/0/0/3", full_b, busy_b, valid_b, addr_b); end
  endtask

  task automatic test_channel();
    qc.delete();
    hp = 2;
    ready_c = 1'b1;
    cmd(2, 1, 0, 0);
    send_frame(16'hA5C3, 16'h1234);
    send_frame(16'hA5C3, 16'h8001);
    tick(4);
    n_vec++; if (qc.size() !== 2) begin n_err++;
      $display("FAIL chan_count: got %0d expected 2", qc.size()); end
    n_vec++; if (qc.size() > 0 && qc[0] !== {16'h1234, 20'd0}) begin n_err++;
      $display("FAIL chan_first: got %h expected 123400000", qc[0]); end
    n_vec++; if (qc.size() > 1 && qc[1] !== {16'h8001, 20'd1}) begin n_err++;
      $display("FAIL chan_second: got %h expected 800100001", qc[1]); end
    n_vec++; if (addr_c !== 20'd2) begin n_err++;
      $display("FAIL chan_addr: got %h expected 2", addr_c); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
    start_a = 0; pause_a = 0; stop_a = 0; ready_a = 0;
    start_b = 0; pause_b = 0; stop_b = 0; ready_b = 0;
    start_c = 0; pause_c = 0; stop_c = 0; ready_c = 0;
    tick(3);
    test_reset();
    rst_n = 1'b1;
    bclk_cycle(1'b1, 1'b0);
    bclk_cycle(1'b1, 1'b0);
    test_capture();
    test_backpressure();
    test_pause();
    test_stop_reset();
    test_full();
    test_channel();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
